// File: rtl/prog_timer.sv
// prog_timer: programmable down-count timer used as a tick/timeout source
// beside the sequencing FSMs.
//
// A start pulse latches load_val (L), prescale (P) and mode, then runs the
// main counter down from L. The counter moves one step every P+1 clk
// cycles. Expiry happens on the first tick that finds the counter at zero,
// so one run lasts (L+1)*(P+1) cycles. One-shot mode returns to IDLE on
// expiry. Periodic mode reloads L and keeps running.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   pulse: latch L/P/mode and (re)start the count
//   stop       in   pulse: abort a running count (wins over start)
//   clr        in   pulse: clear the sticky expired flag
//   mode       in   0 = one-shot, 1 = periodic
//   load_val   in   terminal count L [WIDTH]
//   prescale   in   prescale value P [PRE_W]
//   count      out  current main counter value [WIDTH]
//   busy       out  1 while running
//   timer_out  out  registered one-cycle pulse per expiry
//   expired    out  sticky expiry flag
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | not counting; count/pre_cnt hold their last value
// RUN   | prescaler and main counter active

module prog_timer #(
  parameter int WIDTH = 16,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             timer_out,
  output logic             expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [PRE_W-1:0]   pre_cnt, pre_cnt_n;
  logic [WIDTH-1:0]   l_reg, l_reg_n;
  logic [PRE_W-1:0]   p_reg, p_reg_n;
  logic               m_reg, m_reg_n;
  logic [WIDTH-1:0]   count_n;
  logic               timer_out_n;
  logic               expired_n;
  logic               tick;

  assign tick = (pre_cnt == p_reg);
  // state is itself a flop, so busy is registered along with it
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      pre_cnt   <= '0;
      l_reg     <= '0;
      p_reg     <= '0;
      m_reg     <= 1'b0;
      timer_out <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      pre_cnt   <= pre_cnt_n;
      l_reg     <= l_reg_n;
      p_reg     <= p_reg_n;
      m_reg     <= m_reg_n;
      timer_out <= timer_out_n;
      expired   <= expired_n;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    pre_cnt_n   = pre_cnt;
    l_reg_n     = l_reg;
    p_reg_n     = p_reg;
    m_reg_n     = m_reg;
    timer_out_n = 1'b0;
    // clr is applied first so that a same-cycle expiry can set the flag again
    expired_n   = clr ? 1'b0 : expired;

    if (stop) begin
      // stop freezes the counters. A start in the same cycle is ignored.
      state_n = IDLE;
    end else if (start) begin
      l_reg_n   = load_val;
      p_reg_n   = prescale;
      m_reg_n   = mode;
      count_n   = load_val;
      pre_cnt_n = '0;
      expired_n = 1'b0;
      state_n   = RUN;
    end else if (state == RUN) begin
      pre_cnt_n = tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        if (count != '0) begin
          count_n = count - 1'b1;
        end else begin
          timer_out_n = 1'b1;
          expired_n   = 1'b1;
          if (m_reg) begin
            count_n = l_reg;
          end else begin
            state_n = IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
module tb_prog_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        clr;
  logic        mode;
  logic [15:0] load_val;
  logic [7:0]  prescale;
  logic [15:0] count;
  logic        busy;
  logic        timer_out;
  logic        expired;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] count;
    logic        busy;
    logic        tout;
    logic        expd;
  } exp_t;

  exp_t exp_q[$];

  prog_timer #(.WIDTH(16), .PRE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clr       (clr),
    .mode      (mode),
    .load_val  (load_val),
    .prescale  (prescale),
    .count     (count),
    .busy      (busy),
    .timer_out (timer_out),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  // Push the expected post-edge outputs for the inputs currently driven, take
  // one clock edge, then pop and compare 1 time unit after the edge. The
  // single-cycle pulses are dropped again once the edge has been taken.
  task automatic step(input string tag, input logic [15:0] c, input logic b,
                      input logic t, input logic e);
    exp_t x;
    exp_t got;
    x.tag = tag; x.count = c; x.busy = b; x.tout = t; x.expd = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    clr   = 1'b0;
    got = exp_q.pop_front();
    n_assert++;
    assert (count === got.count) else begin
      n_fail++;
      $error("FAIL %s count: observed %0h expected %0h", got.tag, count, got.count);
    end
    n_assert++;
    assert (busy === got.busy) else begin
      n_fail++;
      $error("FAIL %s busy: observed %0b expected %0b", got.tag, busy, got.busy);
    end
    n_assert++;
    assert (timer_out === got.tout) else begin
      n_fail++;
      $error("FAIL %s timer_out: observed %0b expected %0b", got.tag, timer_out, got.tout);
    end
    n_assert++;
    assert (expired === got.expd) else begin
      n_fail++;
      $error("FAIL %s expired: observed %0b expected %0b", got.tag, expired, got.expd);
    end
  endtask

  initial begin
    // reset overrides a held start
    rst = 1'b1; start = 1'b1; stop = 1'b0; clr = 1'b0;
    mode = 1'b1; load_val = 16'd5; prescale = 8'd0;
    #1;
    step("rst0", 16'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("rst1", 16'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step("idle", 16'd0, 1'b0, 1'b0, 1'b0);

    // one-shot L=4 P=0
    load_val = 16'd4; prescale = 8'd0; mode = 1'b0; start = 1'b1;
    step("os_start", 16'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--)
      step("os_cnt", 16'(i), 1'b1, 1'b0, 1'b0);
    step("os_exp", 16'd0, 1'b0, 1'b1, 1'b1);
    step("os_after", 16'd0, 1'b0, 1'b0, 1'b1);

    // periodic L=2 P=1: period 6
    load_val = 16'd2; prescale = 8'd1; mode = 1'b1; start = 1'b1;
    step("per_start", 16'd2, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 6; k++) begin
        step("per_run", (k < 6) ? 16'(2 - k / 2) : 16'd2, 1'b1,
             k == 6, (p > 0) || (k == 6));
      end
    end
    // clr clears the flag; clr coinciding with expiry leaves it set
    for (int k = 1; k <= 6; k++) begin
      if (k == 1 || k == 6) clr = 1'b1;
      step("per_clr", (k < 6) ? 16'(2 - k / 2) : 16'd2, 1'b1, k == 6, k == 6);
    end
    stop = 1'b1;
    step("per_stop", 16'd2, 1'b0, 1'b0, 1'b1);

    // periodic L=3 P=0, stop after one decrement
    load_val = 16'd3; prescale = 8'd0; mode = 1'b1; start = 1'b1;
    step("stp_start", 16'd3, 1'b1, 1'b0, 1'b0);
    step("stp_cnt", 16'd2, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step("stp_stop", 16'd2, 1'b0, 1'b0, 1'b0);
    step("stp_hold", 16'd2, 1'b0, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    step("stp_both", 16'd2, 1'b0, 1'b0, 1'b0);
    step("stp_both2", 16'd2, 1'b0, 1'b0, 1'b0);

    // restart: one-shot L=10, restart with L=3 after five cycles
    load_val = 16'd10; prescale = 8'd0; mode = 1'b0; start = 1'b1;
    step("rs_start", 16'd10, 1'b1, 1'b0, 1'b0);
    step("rs_cnt", 16'd9, 1'b1, 1'b0, 1'b0);
    load_val = 16'd7; prescale = 8'd5; mode = 1'b1;
    for (int i = 8; i >= 6; i--)
      step("rs_midchg", 16'(i), 1'b1, 1'b0, 1'b0);
    load_val = 16'd3; prescale = 8'd0; mode = 1'b0; start = 1'b1;
    step("rs_restart", 16'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 2; i >= 0; i--)
      step("rs_cnt2", 16'(i), 1'b1, 1'b0, 1'b0);
    step("rs_exp", 16'd0, 1'b0, 1'b1, 1'b1);
    step("rs_after", 16'd0, 1'b0, 1'b0, 1'b1);

    // L=0 P=0 periodic: expiry every edge
    load_val = 16'd0; prescale = 8'd0; mode = 1'b1; start = 1'b1;
    step("z_start", 16'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step("z_run", 16'd0, 1'b1, 1'b1, 1'b1);
    stop = 1'b1;
    step("z_stop", 16'd0, 1'b0, 1'b0, 1'b1);

    // L=max one-shot: full count, no wrap, one pulse
    load_val = 16'hFFFF; prescale = 8'd0; mode = 1'b0; start = 1'b1;
    step("max_start", 16'hFFFF, 1'b1, 1'b0, 1'b0);
    for (int i = 16'hFFFE; i >= 0; i--)
      step("max_cnt", 16'(i), 1'b1, 1'b0, 1'b0);
    step("max_exp", 16'd0, 1'b0, 1'b1, 1'b1);
    step("max_after", 16'd0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
